// File: rtl/inst_fetch_queue_pkg.sv
// Shared CPU types for the fetch queue: address/instruction words, queue entry, default depth.
// Optional build macro used by the queue: INST_FETCH_QUEUE_BYPASS_EN.
package inst_fetch_queue_pkg;

  localparam int FETCH_QUEUE_DEPTH = 8;

  typedef logic [31:0] Address_t;
  typedef logic [31:0] Inst_t;

  typedef struct packed {
    Address_t pc;
    Inst_t    inst;
  } FetchEntry_t;

  // Number of instructions a valid_a/valid_b pair carries; b alone counts as nothing.
  function automatic logic [1:0] pair_count(input logic valid_a, input logic valid_b);
    return valid_a ? (valid_b ? 2'd2 : 2'd1) : 2'd0;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and decode-side signals of the dual-issue instruction queue.
// master = IF/ID pipeline side driving the queue, slave = the queue itself.
interface inst_fetch_queue_if #(
  parameter int DEPTH = inst_fetch_queue_pkg::FETCH_QUEUE_DEPTH
) ();
  import inst_fetch_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic       flush;
  logic       in_valid_a;
  logic       in_valid_b;
  Address_t   in_pc_a;
  Inst_t      in_inst_a;
  Address_t   in_pc_b;
  Inst_t      in_inst_b;
  logic       full;
  logic       id_ready;
  logic       inst2_taken;
  logic       out_valid_a;
  logic       out_valid_b;
  Address_t   out_pc_a;
  Inst_t      out_inst_a;
  Address_t   out_pc_b;
  Inst_t      out_inst_b;
  logic [PTR_W:0] count;

  modport master (
    output flush, in_valid_a, in_valid_b, in_pc_a, in_inst_a, in_pc_b, in_inst_b,
           id_ready, inst2_taken,
    input  full, out_valid_a, out_valid_b, out_pc_a, out_inst_a, out_pc_b, out_inst_b,
           count
  );

  modport slave (
    input  flush, in_valid_a, in_valid_b, in_pc_a, in_inst_a, in_pc_b, in_inst_b,
           id_ready, inst2_taken,
    output full, out_valid_a, out_valid_b, out_pc_a, out_inst_a, out_pc_b, out_inst_b,
           count
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x FetchEntry_t register array: two write ports, two asynchronous read ports.
// The two write addresses are always distinct (tail and tail+1).
module fetch_queue_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_a,
  input  logic [PTR_W-1:0] waddr_a,
  input  FetchEntry_t      wdata_a,
  input  logic             we_b,
  input  logic [PTR_W-1:0] waddr_b,
  input  FetchEntry_t      wdata_b,
  input  logic [PTR_W-1:0] raddr_a,
  output FetchEntry_t      rdata_a,
  input  logic [PTR_W-1:0] raddr_b,
  output FetchEntry_t      rdata_b
);

  FetchEntry_t mem [DEPTH];

  // NOTE: storage has no reset; head/tail/cnt decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (we_a) mem[waddr_a] <= wdata_a;
    if (we_b) mem[waddr_b] <= wdata_b;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between IF and ID: up to two pushes and two pops per cycle.
// Define INST_FETCH_QUEUE_BYPASS_EN to forward IF straight to the slots when the queue is empty.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_queue_if.slave   q
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;

  logic [1:0]  push_n;
  logic [1:0]  pop_n;
  logic [1:0]  wr_n;
  logic [1:0]  deq_n;
  logic        full_int;
  logic        valid_a;
  logic        valid_b;
  FetchEntry_t in_a;
  FetchEntry_t in_b;
  FetchEntry_t stor_a;
  FetchEntry_t stor_b;
  FetchEntry_t slot_a;
  FetchEntry_t slot_b;
  FetchEntry_t wdata_a;
  FetchEntry_t wdata_b;

  assign in_a = '{pc: q.in_pc_a, inst: q.in_inst_a};
  assign in_b = '{pc: q.in_pc_b, inst: q.in_inst_b};

  // Fewer than two free slots: IF holds its whole pair, even if ID pops this cycle.
  assign full_int = (cnt >= CNT_W'(DEPTH - 1));
  assign push_n   = full_int ? 2'd0 : pair_count(q.in_valid_a, q.in_valid_b);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    valid_a = (cnt != '0);
    valid_b = (cnt >= CNT_W'(2));
    slot_a  = stor_a;
    slot_b  = stor_b;
    wr_n    = push_n;
    wdata_a = in_a;
    wdata_b = in_b;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    if ((cnt == '0) && !q.flush) begin
      valid_a = q.in_valid_a;
      valid_b = q.in_valid_a & q.in_valid_b;
      slot_a  = in_a;
      slot_b  = in_b;
    end
`endif
    pop_n = q.id_ready ? ({1'b0, valid_a} + {1'b0, valid_b & q.inst2_taken}) : 2'd0;
    deq_n = pop_n;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    // Consumed bypass instructions never touch storage; only the leftover is written at tail.
    if ((cnt == '0) && !q.flush) begin
      deq_n   = 2'd0;
      wr_n    = push_n - pop_n;
      wdata_a = (pop_n == 2'd1) ? in_b : in_a;
    end
`endif
  end

  fetch_queue_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk     (clk),
    .we_a    (!rst && !q.flush && (wr_n != 2'd0)),
    .waddr_a (tail),
    .wdata_a (wdata_a),
    .we_b    (!rst && !q.flush && (wr_n == 2'd2)),
    .waddr_b (tail + PTR_W'(1)),
    .wdata_b (wdata_b),
    .raddr_a (head),
    .rdata_a (stor_a),
    .raddr_b (head + PTR_W'(1)),
    .rdata_b (stor_b)
  );

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(deq_n);
      tail <= tail + PTR_W'(wr_n);
      cnt  <= cnt + CNT_W'(wr_n) - CNT_W'(deq_n);
    end
  end

  assign q.full        = full_int;
  assign q.count       = cnt;
  assign q.out_valid_a = valid_a;
  assign q.out_valid_b = valid_b;
  assign q.out_pc_a    = valid_a ? slot_a.pc   : '0;
  assign q.out_inst_a  = valid_a ? slot_a.inst : '0;
  assign q.out_pc_b    = valid_b ? slot_b.pc   : '0;
  assign q.out_inst_b  = valid_b ? slot_b.inst : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed plan followed by random traffic,
// compared against a queue-based model of the fetch buffer (follows INST_FETCH_QUEUE_BYPASS_EN).
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = 8;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  FetchEntry_t mq[$];

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, check outputs against the model, then advance the model.
  task automatic step(input string tag, input logic r, input logic fl, input logic va,
                      input logic vb, input Address_t pca, input logic rdy, input logic t2);
    FetchEntry_t ent_a, ent_b, ea, eb;
    FetchEntry_t inc[$];
    logic ev_a, ev_b, efull, byp;
    int n, pops, pushes;

    @(negedge clk);
    ent_a = '{pc: pca,      inst: $urandom};
    ent_b = '{pc: pca + 4,  inst: $urandom};
    rst              = r;
    bus.flush        = fl;
    bus.in_valid_a   = va;
    bus.in_valid_b   = vb;
    bus.in_pc_a      = ent_a.pc;
    bus.in_inst_a    = ent_a.inst;
    bus.in_pc_b      = ent_b.pc;
    bus.in_inst_b    = ent_b.inst;
    bus.id_ready     = rdy;
    bus.inst2_taken  = t2;
    #1;

    n     = mq.size();
    byp   = BYP && (n == 0) && !fl;
    efull = (DEPTH - n) < 2;
    ea    = '0;
    eb    = '0;
    if (byp) begin
      ev_a = va;
      ev_b = va && vb;
      if (ev_a) ea = ent_a;
      if (ev_b) eb = ent_b;
    end else begin
      ev_a = (n >= 1);
      ev_b = (n >= 2);
      if (ev_a) ea = mq[0];
      if (ev_b) eb = mq[1];
    end

    check(tag, "count",   64'(bus.count),       64'(n));
    check(tag, "full",    64'(bus.full),        64'(efull));
    check(tag, "valid_a", 64'(bus.out_valid_a), 64'(ev_a));
    check(tag, "valid_b", 64'(bus.out_valid_b), 64'(ev_b));
    check(tag, "slot_a",  {bus.out_pc_a, bus.out_inst_a}, {ea.pc, ea.inst});
    check(tag, "slot_b",  {bus.out_pc_b, bus.out_inst_b}, {eb.pc, eb.inst});

    pops   = rdy ? (int'(ev_a) + int'(ev_a && ev_b && t2)) : 0;
    pushes = efull ? 0 : (va ? (vb ? 2 : 1) : 0);
    if (pushes >= 1) inc.push_back(ent_a);
    if (pushes == 2) inc.push_back(ent_b);

    if (r || fl) begin
      mq.delete();
    end else if (byp) begin
      for (int i = 0; i < pops; i++) void'(inc.pop_front());
      foreach (inc[i]) mq.push_back(inc[i]);
    end else begin
      for (int i = 0; i < pops; i++) void'(mq.pop_front());
      foreach (inc[i]) mq.push_back(inc[i]);
    end
  endtask

  initial begin
    Address_t pc;
    logic va, vb, rdy, t2, fl, r;

    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid_a  = 1'b0;
    bus.in_valid_b  = 1'b0;
    bus.in_pc_a     = '0;
    bus.in_inst_a   = '0;
    bus.in_pc_b     = '0;
    bus.in_inst_b   = '0;
    bus.id_ready    = 1'b0;
    bus.inst2_taken = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete();

    step("reset_idle", 0, 0, 0, 0, 32'h0, 0, 0);

    // First pair, then four more: six entries 0x80000000..0x80000014
    step("push0",  0, 0, 1, 1, 32'h8000_0000, 0, 0);
    step("push1",  0, 0, 1, 1, 32'h8000_0008, 0, 0);
    step("push2",  0, 0, 1, 1, 32'h8000_0010, 0, 0);
    // Pops 2,1,2,1
    step("pop2a",  0, 0, 0, 0, 32'h0, 1, 1);
    step("pop1a",  0, 0, 0, 0, 32'h0, 1, 0);
    step("pop2b",  0, 0, 0, 0, 32'h0, 1, 1);
    step("pop1b",  0, 0, 0, 0, 32'h0, 1, 0);

    // Fill to DEPTH-1, then a dropped pair while one entry pops
    step("fill0",  0, 0, 1, 1, 32'h8000_0100, 0, 0);
    step("fill1",  0, 0, 1, 1, 32'h8000_0108, 0, 0);
    step("fill2",  0, 0, 1, 1, 32'h8000_0110, 0, 0);
    step("fill3",  0, 0, 1, 0, 32'h8000_0118, 0, 0);
    step("full_drop",  0, 0, 1, 1, 32'h8000_0200, 1, 0);
    step("full_clear", 0, 0, 0, 0, 32'h0, 0, 0);
    step("drain0", 0, 0, 0, 0, 32'h0, 1, 1);
    step("drain1", 0, 0, 0, 0, 32'h0, 1, 1);
    step("drain2", 0, 0, 0, 0, 32'h0, 1, 1);

    // Walk tail to DEPTH-1, then push a pair across the wrap
    step("wrap_s1",   0, 0, 1, 0, 32'h8000_0300, 0, 0);
    step("wrap_s2",   0, 0, 1, 0, 32'h8000_0304, 1, 0);
    step("wrap_pair", 0, 0, 1, 1, 32'h8000_0308, 1, 0);
    step("wrap_pop0", 0, 0, 0, 0, 32'h0, 1, 0);
    step("wrap_pop1", 0, 0, 0, 0, 32'h0, 1, 0);
    step("wrap_end",  0, 0, 0, 0, 32'h0, 0, 0);

    // Flush at count 5 beats a simultaneous push pair and pop 2
    step("fl_fill0",  0, 0, 1, 1, 32'h8000_0400, 0, 0);
    step("fl_fill1",  0, 0, 1, 1, 32'h8000_0408, 0, 0);
    step("fl_fill2",  0, 0, 1, 0, 32'h8000_0410, 0, 0);
    step("flush",     0, 1, 1, 1, 32'h8000_0500, 1, 1);
    step("post_flush", 0, 0, 0, 0, 32'h0, 0, 0);

    // Empty queue pushes consumed in the same cycle (bypass path when enabled)
    step("byp_pair",  0, 0, 1, 1, 32'h8000_0600, 1, 1);
    step("byp_idle",  0, 0, 0, 0, 32'h0, 1, 1);
    step("byp_drain", 0, 0, 0, 0, 32'h0, 1, 1);
    step("byp_half",  0, 0, 1, 1, 32'h8000_0700, 1, 0);
    step("byp_after", 0, 0, 0, 0, 32'h0, 0, 0);

    // Random traffic with occasional flush and reset
    pc = 32'h8000_1000;
    for (int i = 0; i < 400; i++) begin
      va  = ($urandom_range(0, 3) != 0);
      vb  = va && ($urandom_range(0, 1) != 0);
      rdy = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      t2  = ($urandom_range(0, 1) != 0);
      fl  = ($urandom_range(0, 40) == 0);
      r   = ($urandom_range(0, 120) == 0);
      step("rand", r, fl, va, vb, pc, rdy, t2);
      pc  = pc + 32'd8;
    end
    step("final_idle", 0, 0, 0, 0, 32'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-issue instruction queue between the fetch stage and the ID stage.
- Accepts up to two fetched instructions per cycle from IF.
- Presents the two oldest instructions as the slot-a/slot-b pair to the decoders and to the dual-issue decision logic.
- Retires one or two entries per cycle, depending on whether ID accepted the second instruction.
- Flushed on branch redirect or exception.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- PTR_W, $clog2(DEPTH), width of the read/write pointers.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discard all entries (redirect/exception); takes priority over push and pop
- in_valid_a  in  1  fetched instruction a present
- in_valid_b  in  1  fetched instruction b present; only legal with in_valid_a=1
- in_pc_a  in  32  PC of instruction a
- in_inst_a  in  32  instruction word a
- in_pc_b  in  32  PC of instruction b (in_pc_a+4)
- in_inst_b  in  32  instruction word b
- full  out  1  fewer than 2 free entries; IF must hold its pair
- id_ready  in  1  ID consumes this cycle (low during pipeline stall)
- inst2_taken  in  1  ID issued slot b alongside slot a this cycle
- out_valid_a  out  1  slot a holds a valid entry
- out_valid_b  out  1  slot b holds a valid entry
- out_pc_a  out  32  PC of oldest entry
- out_inst_a  out  32  instruction word of oldest entry
- out_pc_b  out  32  PC of second-oldest entry
- out_inst_b  out  32  instruction word of second-oldest entry
- count  out  PTR_W+1  current occupancy

Behaviour:
- State:
  - circular buffer of DEPTH FetchEntry_t entries
  - head (read pointer) and tail (write pointer), both PTR_W bits, wrapping modulo DEPTH
  - cnt, PTR_W+1 bits
- Reset (rst=1 at clk edge): head=0, tail=0, cnt=0. Entry storage is not cleared. The outputs follow from this state: out_valid_a=0, out_valid_b=0, full=0, count=0.
- Outputs are combinational from state (no bypass):
  - out_valid_a = (cnt>=1); out_valid_b = (cnt>=2)
  - slot a reads entry[head]; slot b reads entry[head+1 mod DEPTH]
  - data outputs are forced to 0 when the matching valid is low
- full = (DEPTH-cnt < 2). Evaluated from current state only; an ID pop in the same cycle does not deassert it.
- Push amount: push_n = full ? 0 : (in_valid_a + (in_valid_a & in_valid_b)).
  - a is written at tail, b at tail+1 mod DEPTH
  - tail advances by push_n
  - in_valid_b without in_valid_a is ignored (push_n=0)
- Pop amount: pop_n = id_ready ? (out_valid_a + (out_valid_b & inst2_taken)) : 0.
  - head advances by pop_n
  - inst2_taken with out_valid_b=0 pops only one entry
- Simultaneous push and pop: cnt_next = cnt + push_n - pop_n. Both pointers update in the same cycle.
- Pointer wrap: tail=DEPTH-1 with push_n=2 writes entries DEPTH-1 and 0, giving tail_next=1. head wraps the same way.
- Flush: head_next=0, tail_next=0, cnt_next=0 regardless of push/pop. Instructions presented in the flush cycle are dropped; IF re-fetches from the redirect target.
- Reset or flush mid-operation: all entries are lost; no partial state survives.
- Latency, instruction pushed in cycle N:
  - appears at slot a/b in cycle N+1 at the earliest
  - with INST_FETCH_QUEUE_BYPASS_EN, in cycle N when the queue is empty

Optional Feature:
- Macro: INST_FETCH_QUEUE_BYPASS_EN
- Defined:
  - When cnt=0 and flush=0, out_* are driven directly from in_* (in_valid_a appears as out_valid_a, in_valid_b as out_valid_b).
  - Bypassed instructions consumed in that same cycle (per pop_n) are not written into the queue. Only the unconsumed remainder is written, at tail.
  - cnt_next = push_n - pop_n.
  - When cnt=1, slot b is not bypassed.
- Undefined: outputs come from storage only; one extra cycle of fetch-to-decode latency.

Decomposition:
- Shared cpu package gains:
  - FetchEntry_t struct {pc: Address_t, inst: Inst_t}
  - FETCH_QUEUE_DEPTH constant, default 8
- Single sub-module fetch_queue_ram: DEPTH x FetchEntry_t register array with 2 write ports and 2 asynchronous read ports.
- Pointer, count and bypass logic stays in inst_fetch_queue.

Test Plan:
- Reset then push pair (PC 0x80000000/0x80000004) -> next cycle out_valid_a=out_valid_b=1 with matching PCs, count=2.
- id_ready=1 with inst2_taken alternating 1,0 over 6 entries -> pops go 2,1,2,1; out_pc_a sequence 0x80000000, 0x80000008, 0x8000000C, 0x80000014.
- Fill to cnt=DEPTH-1 -> full=1; push pair is dropped and count stays 7. Pop 1 in that cycle -> count=6, full deasserts next cycle.
- tail=DEPTH-1, push pair -> entries land at indices 7 and 0, tail=1; subsequent pops return the PCs in order.
- count=5 with simultaneous push pair, pop 2 and flush=1 -> next cycle count=0 and out_valid_a=0.
- Bypass build, empty queue, push pair with id_ready=1, inst2_taken=1 -> both visible the same cycle, count stays 0; with inst2_taken=0 -> count=1 and slot a holds the b instruction next cycle.
